// File: rtl/sigma_bus_pkg.sv
// Shared types and constants for the sigma data-bus arbiter.
package sigma_bus_pkg;

  localparam int unsigned NUM_M = 2;
  localparam int unsigned M_CPU = 0;
  localparam int unsigned M_UDM = 1;

  // One-hot grant for the debug master; also the last-grant reset value.
  localparam logic [NUM_M-1:0] GRANT_UDM = 2'b10;

  // The request struct is sized for the widest supported bus (64-bit address and data).
  // Narrower instances zero-extend into it and truncate back out.
  localparam int unsigned BUS_ADDR_W = 64;
  localparam int unsigned BUS_DATA_W = 64;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StResp = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sigma_arb_pick.sv
// Combinational winner selection for the two-master sigma bus arbiter.
// SIGMA_ARB_RR_EN: round-robin on a tie; otherwise fixed priority with UDM over CPU.
module sigma_arb_pick
  import sigma_bus_pkg::*;
(
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] last_grant_i,
  output logic [NUM_M-1:0] grant_o
);

`ifdef SIGMA_ARB_RR_EN
  // A lone requester wins outright; on a tie the master not granted last wins.
  always_comb begin
    grant_o = req_i;
    if (&req_i) begin
      grant_o = '0;
      if (last_grant_i[M_CPU]) begin
        grant_o[M_UDM] = 1'b1;
      end else begin
        grant_o[M_CPU] = 1'b1;
      end
    end
  end
`else
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;

  // UDM preempts CPU whenever both request.
  always_comb begin
    grant_o = '0;
    if (req_i[M_UDM]) begin
      grant_o[M_UDM] = 1'b1;
    end else if (req_i[M_CPU]) begin
      grant_o[M_CPU] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sigma_bus_arb.sv
// Two-master (CPU, UDM) to one-slave arbiter for the sigma data bus.
// Sequences each transaction through IDLE -> CMD -> (RESP) -> IDLE.
// SIGMA_ARB_RR_EN: enables round-robin arbitration and the last-grant register.
module sigma_bus_arb
  import sigma_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                             clk_i,
  input  logic                             arst_n_i,
  input  logic [NUM_M-1:0]                 m_req_i,
  input  logic [NUM_M-1:0]                 m_we_i,
  input  logic [NUM_M-1:0][ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_M-1:0][DATA_W/8-1:0]   m_be_i,
  input  logic [NUM_M-1:0][DATA_W-1:0]     m_wdata_i,
  output logic [NUM_M-1:0]                 m_ack_o,
  output logic [NUM_M-1:0]                 m_resp_o,
  output logic [NUM_M-1:0][DATA_W-1:0]     m_rdata_o,
  output logic                             s_req_o,
  output logic                             s_we_o,
  output logic [ADDR_W-1:0]                s_addr_o,
  output logic [DATA_W/8-1:0]              s_be_o,
  output logic [DATA_W-1:0]                s_wdata_o,
  input  logic                             s_ack_i,
  input  logic                             s_resp_i,
  input  logic [DATA_W-1:0]                s_rdata_i,
  output logic [NUM_M-1:0]                 grant_o
);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [NUM_M-1:0] pick_grant;
  logic [NUM_M-1:0] last_grant;
  logic             gidx;
  bus_req_t         sel;

  sigma_arb_pick u_pick (
    .req_i       (m_req_i),
    .last_grant_i(last_grant),
    .grant_o     (pick_grant)
  );

  // grant_q is one-hot or zero, so the UDM bit doubles as the owner index.
  assign gidx    = grant_q[M_UDM];
  assign grant_o = grant_q;

  // Select the owning master's command fields.
  always_comb begin
    sel.we    = m_we_i[gidx];
    sel.addr  = BUS_ADDR_W'(m_addr_i[gidx]);
    sel.be    = BUS_BE_W'(m_be_i[gidx]);
    sel.wdata = BUS_DATA_W'(m_wdata_i[gidx]);
  end

`ifdef SIGMA_ARB_RR_EN
  logic [NUM_M-1:0] last_q, last_d;

  // Record the winner on every IDLE -> CMD hand-off.
  always_comb begin
    last_d = last_q;
    if ((state_q == StIdle) && (|m_req_i)) begin
      last_d = pick_grant;
    end
  end

  // Last-grant register; resets to UDM so the CPU wins the first tie.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_q <= GRANT_UDM;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = GRANT_UDM;
`endif

  // Next-state, grant update and all bus-side outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_ack_o   = '0;
    m_resp_o  = '0;
    m_rdata_o = '0;
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (|m_req_i) begin
          grant_d = pick_grant;
          state_d = StCmd;
        end
      end
      StCmd: begin
        s_req_o        = m_req_i[gidx];
        s_we_o         = sel.we;
        s_addr_o       = ADDR_W'(sel.addr);
        s_be_o         = (DATA_W/8)'(sel.be);
        s_wdata_o      = DATA_W'(sel.wdata);
        m_ack_o[gidx]  = s_ack_i;
        // A withdrawn request abandons the slot; no slave command went out.
        if (!m_req_i[gidx]) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (s_ack_i) begin
          if (sel.we) begin
            state_d = StIdle;
            grant_d = '0;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        m_resp_o[gidx]  = s_resp_i;
        m_rdata_o[gidx] = s_rdata_i;
        if (s_resp_i) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_sigma_bus_arb.sv
// Bench for sigma_bus_arb: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of ownership and the arbitration rule.
module tb_sigma_bus_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic               clk;
  logic               arst_n;
  logic [1:0]         m_req, m_we, m_ack, m_resp, grant;
  logic [1:0][AW-1:0] m_addr;
  logic [1:0][BW-1:0] m_be;
  logic [1:0][DW-1:0] m_wdata, m_rdata;
  logic               s_req, s_we, s_ack, s_resp;
  logic [AW-1:0]      s_addr;
  logic [BW-1:0]      s_be;
  logic [DW-1:0]      s_wdata, s_rdata;

  int total = 0;
  int bad   = 0;

  sigma_bus_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .m_req_i  (m_req),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_be_i   (m_be),
    .m_wdata_i(m_wdata),
    .m_ack_o  (m_ack),
    .m_resp_o (m_resp),
    .m_rdata_o(m_rdata),
    .s_req_o  (s_req),
    .s_we_o   (s_we),
    .s_addr_o (s_addr),
    .s_be_o   (s_be),
    .s_wdata_o(s_wdata),
    .s_ack_i  (s_ack),
    .s_resp_i (s_resp),
    .s_rdata_i(s_rdata),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner among requesters given the last owner (0 = CPU, 1 = UDM).
  function automatic int pick(input logic [1:0] req, input int last);
`ifdef SIGMA_ARB_RR_EN
    if (req == 2'b11) return 1 - last;
`else
    if (last > 1) return 0;
`endif
    return req[1] ? 1 : 0;
  endfunction

  // Model: who owns the bus (-1 none), and whether the owner's read was accepted.
  int mo_owner = -1;
  bit mo_wait  = 1'b0;
  int mo_last  = 1;

  always @(negedge clk) begin : cmp
    logic [1:0]         eg, ea, er;
    logic               es;
    logic [32:0]        ewa;
    logic [35:0]        ebw;
    logic [1:0][DW-1:0] erd;
    int                 nown;
    bit                 nwait;
    eg = '0; ea = '0; er = '0; es = 1'b0; ewa = '0; ebw = '0; erd = '0;
    nown = mo_owner;
    nwait = mo_wait;
    if (!arst_n) begin
      nown = -1;
      nwait = 1'b0;
      mo_last = 1;
    end else if (mo_owner < 0) begin
      if (m_req != 2'b00) begin
        nown = pick(m_req, mo_last);
        nwait = 1'b0;
        mo_last = nown;
      end
    end else if (!mo_wait) begin
      eg[mo_owner] = 1'b1;
      es = m_req[mo_owner];
      ewa = {m_we[mo_owner], m_addr[mo_owner]};
      ebw = {m_be[mo_owner], m_wdata[mo_owner]};
      ea[mo_owner] = s_ack;
      if (!m_req[mo_owner]) nown = -1;
      else if (s_ack) begin
        if (m_we[mo_owner]) nown = -1;
        else nwait = 1'b1;
      end
    end else begin
      eg[mo_owner] = 1'b1;
      er[mo_owner] = s_resp;
      erd[mo_owner] = s_rdata;
      if (s_resp) begin
        nown = -1;
        nwait = 1'b0;
      end
    end
    chk("cyc_grant", grant, eg);
    chk("cyc_s_req", s_req, es);
    chk("cyc_s_we_addr", {s_we, s_addr}, ewa);
    chk("cyc_s_be_wdata", {s_be, s_wdata}, ebw);
    chk("cyc_m_ack", m_ack, ea);
    chk("cyc_m_resp", m_resp, er);
    chk("cyc_m_rdata", m_rdata, erd);
    mo_owner = nown;
    mo_wait = nwait;
  end

  int         exp_g[6];
  int         n;
  logic [1:0] pend, acked;
  int         rcnt;

  initial begin
`ifdef SIGMA_ARB_RR_EN
    exp_g = '{1, 2, 1, 2, 1, 2};
`else
    exp_g = '{2, 2, 2, 2, 2, 2};
`endif
    // Reset with busy-looking inputs: everything must still be quiet.
    arst_n = 1'b0;
    m_req = 2'b11; m_we = 2'b00; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hFFFF_FFFF;
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_m_ack", m_ack, 2'b00);
    chk("rst_m_resp", m_resp, 2'b00);
    chk("rst_m_rdata", m_rdata, 64'h0);
    m_req = 2'b00; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // Single CPU write, slave acks immediately.
    tick();
    m_req = 2'b01; m_we = 2'b01; m_addr[0] = 32'h8000_0000;
    m_wdata[0] = 32'hDEAD_BEEF; m_be[0] = 4'hF; s_ack = 1'b1;
    #2 chk("wr_t_s_req", s_req, 1'b0);
    chk("wr_t_grant", grant, 2'b00);
    tick();
    #2 chk("wr_t1_s_req", s_req, 1'b1);
    chk("wr_t1_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_t1_addr", s_addr, 32'h8000_0000);
    chk("wr_t1_ack", m_ack, 2'b01);
    chk("wr_t1_grant", grant, 2'b01);
    tick();
    m_req = 2'b00; s_ack = 1'b0;
    #2 chk("wr_idle_grant", grant, 2'b00);

    // UDM read, response 3 cycles after ack.
    tick();
    m_req = 2'b10; m_we = 2'b00; m_addr[1] = 32'h8000_0004; m_be[1] = 4'hF;
    tick();
    s_ack = 1'b1;
    #2 chk("rd_cmd_grant", grant, 2'b10);
    chk("rd_cmd_ack", m_ack, 2'b10);
    tick();
    m_req = 2'b00; s_ack = 1'b0;
    #2 chk("rd_w1_grant", grant, 2'b10);
    chk("rd_w1_resp", m_resp, 2'b00);
    tick();
    #2 chk("rd_w2_grant", grant, 2'b10);
    tick();
    s_resp = 1'b1; s_rdata = 32'h0000_0030;
    #2 chk("rd_resp", m_resp, 2'b10);
    chk("rd_rdata1", m_rdata[1], 32'h30);
    chk("rd_rdata0", m_rdata[0], 32'h0);
    chk("rd_resp_grant", grant, 2'b10);
    tick();
    s_resp = 1'b0; s_rdata = '0;
    #2 chk("rd_idle_grant", grant, 2'b00);

    // Continuous write contention: six grants.
    tick();
    m_req = 2'b11; m_we = 2'b11; s_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #2;
      if (grant != 2'b00) begin
        chk($sformatf("cont_%0d", n), grant, 64'(exp_g[n]));
        n++;
      end
      tick();
    end
    if (n < 6) chk("cont_timeout", n, 6);
    m_req = 2'b00; s_ack = 1'b0;

    // Reset while in RESP, slave answers after release.
    tick();
    m_req = 2'b01; m_we = 2'b00; m_addr[0] = 32'h0000_0100;
    tick();
    s_ack = 1'b1;
    #2 chk("rr_cmd_grant", grant, 2'b01);
    tick();
    m_req = 2'b00; s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'h55;
    arst_n = 1'b0;
    #2 chk("rr_in_grant", grant, 2'b00);
    chk("rr_in_resp", m_resp, 2'b00);
    chk("rr_in_rdata", m_rdata, 64'h0);
    chk("rr_in_s_req", s_req, 1'b0);
    tick();
    arst_n = 1'b1;
    #2 chk("rr_post_resp", m_resp, 2'b00);
    chk("rr_post_rdata", m_rdata, 64'h0);
    chk("rr_post_grant", grant, 2'b00);
    tick();
    s_resp = 1'b0; s_rdata = '0;
    #2 chk("rr_idle_grant", grant, 2'b00);

    // CPU withdraws in CMD while UDM is pending.
    tick();
    m_req = 2'b01; m_we = 2'b11; m_addr[0] = 32'h0000_0A00; m_addr[1] = 32'h0000_0B00;
    tick();
    m_req = 2'b10;
    #2 chk("wd_grant0", grant, 2'b01);
    chk("wd_no_cmd", s_req, 1'b0);
    chk("wd_no_ack", m_ack, 2'b00);
    tick();
    #2 chk("wd_idle", grant, 2'b00);
    tick();
    s_ack = 1'b1;
    #2 chk("wd_m1_grant", grant, 2'b10);
    chk("wd_m1_s_req", s_req, 1'b1);
    chk("wd_m1_addr", s_addr, 32'h0000_0B00);
    chk("wd_m1_ack", m_ack, 2'b10);
    tick();
    m_req = 2'b00; s_ack = 1'b0;

    // Stray slave response in IDLE.
    tick();
    s_resp = 1'b1; s_rdata = 32'h99;
    #2 chk("stray_resp", m_resp, 2'b00);
    chk("stray_rdata", m_rdata, 64'h0);
    chk("stray_grant", grant, 2'b00);
    tick();
    s_resp = 1'b0; s_rdata = '0;
    #2 chk("stray_after", grant, 2'b00);

    // Randomized traffic; the compare process checks every cycle.
    pend = 2'b00; acked = 2'b00; rcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) arst_n = 1'b0;
      if (c == 1502) arst_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (acked[m]) pend[m] = 1'b0;
        if (pend[m] && $urandom_range(0, 39) == 0) begin
          pend[m] = 1'b0;
        end else if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          m_we[m] = 1'($urandom);
          m_addr[m] = $urandom;
          m_be[m] = 4'($urandom);
          m_wdata[m] = $urandom;
        end
      end
      m_req = pend;
      s_ack = 1'($urandom);
      s_resp = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        s_resp = (rcnt == 0);
      end
      if ($urandom_range(0, 15) == 0) s_resp = 1'b1;
      s_rdata = $urandom;
      #2;
      acked = m_ack & m_req;
      if (s_req && s_ack && !s_we) rcnt = $urandom_range(1, 3);
    end

    tick();
    m_req = 2'b00; s_ack = 1'b0; s_resp = 1'b0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
